// File: rtl/trace_pkg.sv
// Shared types and constants for the commit-trace capture unit.
// A record is one header byte followed by PC, instruction and write data.
package trace_pkg;

   localparam int REC_BYTES = 13;
   localparam int REC_W     = 8 * REC_BYTES;

   localparam int HDR_WE   = 7;
   localparam int HDR_LOST = 6;
   localparam int HDR_HALT = 5;

   typedef struct packed {
      logic        we;
      logic        lost;
      logic        halt;
      logic [4:0]  waddr;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] wdata;
   } trace_rec_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } ser_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
   parameter int DATA_W = 104,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wptr, rptr;
   logic              do_wr, do_rd;

   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty = (wptr == rptr);
   assign do_rd = pop && !empty;
   assign do_wr = push && (!full || do_rd);
   assign rdata = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures retiring instructions into a record FIFO and drains it as a byte
// stream with valid/ready handshaking; capture stops at the program-end marker.
module cpu_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int MIN_COMMITS = 20
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   commit_valid,
   input  logic [31:0]            pc,
   input  logic [31:0]            inst,
   input  logic                   rf_we,
   input  logic [4:0]             rf_waddr,
   input  logic [31:0]            rf_wdata,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   halted
);

   localparam logic [3:0] LAST_IDX = 4'(REC_BYTES - 1);

   trace_rec_t        rec_in;
   logic [7:0]        hdr;
   logic [REC_W-1:0]  rec_out;
   logic [REC_W-1:0]  sr;
   logic [3:0]        idx;
   ser_state_t        state;
   logic [15:0]       commits;
   logic              lost;
   logic              capture, halt_fire, push_ok, drop, pop;
   logic              fifo_full, fifo_empty;

   assign capture   = en && commit_valid && !halted;
   assign halt_fire = capture && (inst == 32'd0) && (int'(commits) >= MIN_COMMITS);
   assign pop       = !fifo_empty &&
                      ((state == S_IDLE) || (tx_ready && idx == LAST_IDX));
   assign push_ok   = capture && (!fifo_full || pop);
   assign drop      = capture && fifo_full && !pop;

   always_comb begin
      hdr           = '0;
      hdr[HDR_WE]   = rf_we;
      hdr[HDR_LOST] = lost;
      hdr[HDR_HALT] = halt_fire;
      hdr[4:0]      = rf_waddr;
      rec_in        = {hdr, pc, inst, rf_wdata};
   end

   trace_fifo #(.DATA_W(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop),
      .wdata (rec_in),
      .rdata (rec_out),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   // capture side: drop tracking, commit counter, halt latch
   always_ff @(posedge clk) begin
      if (reset) begin
         lost     <= 1'b0;
         overflow <= 1'b0;
         halted   <= 1'b0;
         commits  <= '0;
      end else begin
         if (push_ok) begin
            lost <= 1'b0;
            if (commits != 16'hFFFF) commits <= commits + 16'd1;
         end else if (drop) begin
            lost     <= 1'b1;
            overflow <= 1'b1;
         end
         if (halt_fire) halted <= 1'b1;
      end
   end

   // serializer: tx_data always holds the byte at idx, sr the bytes after it
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         idx      <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  tx_data  <= rec_out[REC_W-1 -: 8];
                  sr       <= {rec_out[REC_W-9:0], 8'h00};
                  idx      <= '0;
                  tx_valid <= 1'b1;
                  state    <= S_SEND;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  if (idx == LAST_IDX) begin
                     if (!fifo_empty) begin
                        tx_data <= rec_out[REC_W-1 -: 8];
                        sr      <= {rec_out[REC_W-9:0], 8'h00};
                        idx     <= '0;
                     end else begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                     end
                  end else begin
                     tx_data <= sr[REC_W-1 -: 8];
                     sr      <= {sr[REC_W-9:0], 8'h00};
                     idx     <= idx + 4'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
